// File: rtl/regfile_mp.sv
// Multi-ported register file: two combinational read ports, two write ports
// (port 0 wins on collision) and a per-register pending-write scoreboard.
module regfile_mp #(
  parameter int NB_DATA  = 32,
  parameter int NB_REG   = 5,
  parameter bit ZERO_REG = 1'b1,
  parameter bit BYPASS   = 1'b1
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic [NB_REG-1:0]  i_rd_addr1,
  input  logic [NB_REG-1:0]  i_rd_addr2,
  output logic [NB_DATA-1:0] o_rd_data1,
  output logic [NB_DATA-1:0] o_rd_data2,
  output logic               o_busy1,
  output logic               o_busy2,
  input  logic               i_we0,
  input  logic [NB_REG-1:0]  i_wr_addr0,
  input  logic [NB_DATA-1:0] i_wr_data0,
  input  logic               i_we1,
  input  logic [NB_REG-1:0]  i_wr_addr1,
  input  logic [NB_DATA-1:0] i_wr_data1,
  input  logic               i_issue_valid,
  input  logic [NB_REG-1:0]  i_issue_reg,
  output logic               o_wr_conflict
);

  localparam int DEPTH = 2 ** NB_REG;

  logic [NB_DATA-1:0] regs [DEPTH];
  logic [DEPTH-1:0]   pending;

  // Register 0 is treated as a constant when ZERO_REG is set.
  function automatic logic is_zero(input logic [NB_REG-1:0] addr);
    return ZERO_REG && (addr == '0);
  endfunction

  function automatic logic [NB_DATA-1:0] read_port(
    input logic [NB_REG-1:0]  addr,
    input logic [NB_DATA-1:0] stored
  );
    logic [NB_DATA-1:0] value;
    value = stored;
    if (BYPASS && i_rst_n) begin
      if (i_we0 && (i_wr_addr0 == addr))      value = i_wr_data0;
      else if (i_we1 && (i_wr_addr1 == addr)) value = i_wr_data1;
    end
    if (is_zero(addr)) value = '0;
    return value;
  endfunction

  // Busy drops early only when a same-cycle write clears the bit and no issue re-sets it.
  function automatic logic busy_port(
    input logic [NB_REG-1:0] addr,
    input logic              bit_val
  );
    logic wr_hit;
    logic iss_hit;
    logic value;
    wr_hit  = (i_we0 && (i_wr_addr0 == addr)) || (i_we1 && (i_wr_addr1 == addr));
    iss_hit = i_issue_valid && (i_issue_reg == addr);
    value   = bit_val;
    if (BYPASS && i_rst_n && wr_hit && !iss_hit) value = 1'b0;
    if (is_zero(addr)) value = 1'b0;
    return value;
  endfunction

  always_comb begin
    o_rd_data1 = read_port(i_rd_addr1, regs[i_rd_addr1]);
    o_rd_data2 = read_port(i_rd_addr2, regs[i_rd_addr2]);
    o_busy1    = busy_port(i_rd_addr1, pending[i_rd_addr1]);
    o_busy2    = busy_port(i_rd_addr2, pending[i_rd_addr2]);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs[i]    <= '0;
        pending[i] <= 1'b0;
      end
      o_wr_conflict <= 1'b0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        logic [NB_REG-1:0] a;
        logic              hit0;
        logic              hit1;
        a    = i[NB_REG-1:0];
        hit0 = i_we0 && (i_wr_addr0 == a);
        hit1 = i_we1 && (i_wr_addr1 == a);
        if (!is_zero(a)) begin
          if (hit0)      regs[i] <= i_wr_data0;
          else if (hit1) regs[i] <= i_wr_data1;
          // Issue has priority over clear so a re-issued destination stays pending.
          if (i_issue_valid && (i_issue_reg == a)) pending[i] <= 1'b1;
          else if (hit0 || hit1)                  pending[i] <= 1'b0;
        end
      end
      o_wr_conflict <= i_we0 && i_we1 && (i_wr_addr0 == i_wr_addr1);
    end
  end

endmodule

// File: doc/regfile_mp.md
REGFILE_MP -- requirements
Module: regfile_mp

Interface
REQ-001 The block SHALL have parameter NB_DATA, default 32: register width in bits.
REQ-002 The block SHALL have parameter NB_REG, default 5: address width; depth = 2**NB_REG.
REQ-003 The block SHALL have parameter ZERO_REG, default 1: when 1, register 0 is hardwired to zero.
REQ-004 The block SHALL have parameter BYPASS, default 1: when 1, same-cycle write data is forwarded to the read ports.
REQ-005 The block SHALL have port i_clk, input, 1 bit: the only clock; all state updates on its rising edge.
REQ-006 The block SHALL have port i_rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-007 The block SHALL have ports i_rd_addr1 and i_rd_addr2, input, NB_REG bits each: read addresses.
REQ-008 The block SHALL have ports o_rd_data1 and o_rd_data2, output, NB_DATA bits each: read data.
REQ-009 The block SHALL have ports o_busy1 and o_busy2, output, 1 bit each: pending-write flag of the register addressed by the matching read port.
REQ-010 The block SHALL have write port 0 with i_we0 (1 bit), i_wr_addr0 (NB_REG bits) and i_wr_data0 (NB_DATA bits), all inputs.
REQ-011 The block SHALL have write port 1 with i_we1 (1 bit), i_wr_addr1 (NB_REG bits) and i_wr_data1 (NB_DATA bits), all inputs.
REQ-012 The block SHALL have ports i_issue_valid, input, 1 bit, and i_issue_reg, input, NB_REG bits: marks a destination register as pending.
REQ-013 The block SHALL have port o_wr_conflict, output, 1 bit: registered flag set when both write ports target the same address in one cycle.

Function
REQ-014 Writes SHALL take effect at the rising edge of i_clk: registers[i_wr_addrN] <= i_wr_dataN when i_weN=1.
REQ-015 When both write ports are enabled with the same address, port 0 SHALL win, and o_wr_conflict SHALL be 1 in the following cycle; otherwise o_wr_conflict SHALL be 0.
REQ-016 Reads SHALL be combinational with zero-cycle latency from the array.
REQ-017 With BYPASS=1, a read address that matches an enabled write address SHALL return that write data in the same cycle, with port 0 taking priority over port 1; with BYPASS=0, reads SHALL return the pre-edge array contents.
REQ-018 With ZERO_REG=1, writes to address 0 SHALL be ignored and reads of address 0 SHALL return 0, bypass included; address 0 SHALL never become busy.
REQ-019 The block SHALL keep a scoreboard of 2**NB_REG pending bits; the bit for i_issue_reg SHALL be set at the clock edge when i_issue_valid=1.
REQ-020 A pending bit SHALL be cleared at the clock edge by any enabled write port targeting its address.
REQ-021 If an issue and a write target the same register in the same cycle, set SHALL win and the bit SHALL be 1 afterwards.
REQ-022 o_busyN SHALL be combinational from the scoreboard bit for i_rd_addrN; with BYPASS=1 it SHALL read 0 when a same-cycle write clears that bit and no same-cycle issue sets it.
REQ-023 Out-of-range behaviour SHALL be impossible because all addresses are full-width; there SHALL be no wrap-around state.

Reset
REQ-024 While i_rst_n=0, all registers, all scoreboard bits and o_wr_conflict SHALL be 0 asynchronously, so o_rd_data1/2=0 and o_busy1/2=0.
REQ-025 Write, issue and clear inputs SHALL be ignored while i_rst_n=0; after deassertion, the first update SHALL occur on the next rising edge.

Verification
REQ-026 Reset: set random contents, pulse i_rst_n=0 mid-cycle -> all reads 0 and all busy flags 0 immediately, without waiting for a clock.
REQ-027 Dual write: we0 to r5=0xAAAA0000 and we1 to r5=0x5555FFFF on the same edge -> r5 reads 0xAAAA0000 and o_wr_conflict=1 for one cycle; a distinct-address dual write -> both registers updated and o_wr_conflict=0.
REQ-028 Bypass: BYPASS=1 with rd_addr1=7 and we1 to r7=0x12345678 in the same cycle -> o_rd_data1=0x12345678 before the edge; BYPASS=0 -> old value before the edge, new value after.
REQ-029 Zero register: ZERO_REG=1 with a write of 0xFFFFFFFF to r0 plus an issue of r0 -> reads 0 and busy 0; ZERO_REG=0 -> reads 0xFFFFFFFF.
REQ-030 Scoreboard: issue r3 -> o_busy1=1 at rd_addr1=3; a later write to r3 -> busy 0 after the edge; issue and write of r3 on the same edge -> busy stays 1.
